// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the write port of an asynchronous FIFO
// (winc / wdata / full) between NUM_REQ requesters living in the write clock
// domain. One requester at a time owns the port for a locked burst. The burst
// ends on req_last, after MAX_BURST beats, or when the owner drops valid. One
// idle cycle separates consecutive bursts, and that cycle is used to arbitrate.
//
// Parameters:
//   NUM_REQ    : number of requesters (2..16)
//   DATA_WIDTH : FIFO data width
//   MAX_BURST  : beats per grant before forced re-arbitration (>= 1)
//
// Ports:
//   wclk       in   write-domain clock
//   wrst_n     in   asynchronous active-low reset
//   req_valid  in   per-requester data valid
//   req_data   in   packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   in   final beat of the requester's burst
//   req_ready  out  beat accepted this cycle (one-hot or zero)
//   full       in   FIFO full flag from the write-side control
//   winc       out  FIFO write increment (never high while full is high)
//   wdata      out  FIFO write data (slice of the granted requester)
//   grant_id   out  currently / last granted requester
//   busy       out  a burst grant is active
//   stall_cnt  out  cycles a granted, valid requester was held off by full
//
// Build option:
//   FIFO_WR_ARB_STALL_CNT_EN - when defined, stall_cnt is a saturating 16-bit
//   counter cleared only by reset; otherwise stall_cnt is tied to zero and no
//   counter logic is built.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    // beat_cnt value at which the beat being taken is the last one allowed
    localparam logic [BW-1:0] LAST_BEAT_CNT = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] LAST_ID       = GW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
    logic                  gnt_valid;
    logic                  gnt_last;
    logic                  beat;
    logic                  burst_done;
    logic [GW-1:0]         next_id;
    logic [GW-1:0]         pick_id;

    // -------------------------------------------------------------------------
    // Unpack requester data and build the per-requester ready strobes.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_word[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[gi] = beat && (grant_id_q == GW'(gi));
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first set bit at or above ptr, wrapping at NUM_REQ.
    // Only used when at least one valid bit is set.
    // -------------------------------------------------------------------------
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [GW-1:0]      ptr);
        logic [GW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && vld[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
        return sel;
    endfunction

    assign pick_id = rr_pick(req_valid, rr_ptr_q);

    // Requester after the current owner; the pointer moves past the owner
    // whenever its burst ends, which is what gives the fairness bound.
    assign next_id = (grant_id_q == LAST_ID) ? '0 : grant_id_q + GW'(1);

    assign gnt_valid  = req_valid[grant_id_q];
    assign gnt_last   = req_last[grant_id_q];

    // full gates the beat combinationally, so a full flag rising mid-burst
    // stalls the very same cycle and winc can never coincide with full.
    assign beat       = (state_q == BURST) && gnt_valid && !full;
    assign burst_done = gnt_last || (beat_cnt_q == LAST_BEAT_CNT);

    // -------------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state and register updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            IDLE: begin
                // Arbitration cycle: no transfer happens here.
                if (|req_valid) begin
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end

            BURST: begin
                if (!gnt_valid) begin
                    // Owner went away: release without a transfer.
                    state_d    = IDLE;
                    rr_ptr_d   = next_id;
                    beat_cnt_d = '0;
                end else if (beat) begin
                    if (burst_done) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_id;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
                // valid && full: hold the grant, beat count frozen.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        winc     = beat;
        busy     = (state_q == BURST);
        wdata    = req_word[grant_id_q];
        grant_id = grant_id_q;
    end

    // -------------------------------------------------------------------------
    // Optional full-stall counter
    // -------------------------------------------------------------------------
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    assign stall = (state_q == BURST) && gnt_valid && full;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
// Each requester is a small word queue; the words expected on the FIFO write
// port are pushed to a scoreboard in arbitration order and popped on winc.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic             wclk = 1'b0;
    logic             wrst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             full;
    logic             winc;
    logic [DW-1:0]    wdata;
    logic [1:0]       grant_id;
    logic             busy;
    logic [15:0]      stall_cnt;

    logic [NR-1:0]    hold = '0;
    logic [DW:0]      mem [NR][64];
    int               head [NR];
    int               tail [NR];
    logic [DW+1:0]    exp_q [$];
    logic [NR-1:0]    acc;
    int               n_assert = 0;
    int               n_fail   = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .full     (full),
        .winc     (winc),
        .wdata    (wdata),
        .grant_id (grant_id),
        .busy     (busy),
        .stall_cnt(stall_cnt)
    );

    always #5 wclk = ~wclk;

    // Requesters present the head of their queue until it is accepted.
    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]           = ~hold[i];
                req_last[i]            = mem[i][head[i]][DW];
                req_data[i*DW +: DW]   = mem[i][head[i]][DW-1:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] d, input logic last);
        mem[i][tail[i]] = {last, d};
        tail[i]++;
    endtask

    task automatic expect_wr(input int i, input logic [DW-1:0] d);
        exp_q.push_back({2'(i), d});
    endtask

    // One clock: scoreboard check at the falling edge, accepted beats leave
    // the requester queues just after the rising edge.
    task automatic tick();
        logic [DW+1:0] e;
        @(negedge wclk);
        acc = req_ready;
        if (wrst_n === 1'b1 && winc === 1'b1) begin
            $display("write: id=%0d data=%08h", grant_id, wdata);
            chk("wr_full_gate", 64'(full), 64'd0);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_id",    64'(grant_id),  64'(e[DW+1:DW]));
                chk("wr_data",  64'(wdata),     64'(e[DW-1:0]));
                chk("wr_ready", 64'(req_ready), 64'(4'b0001 << e[DW+1:DW]));
            end
        end
        @(posedge wclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) head[i]++;
        end
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && k < 300) begin
            tick();
            k++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int k;
        int cnt;

        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        wrst_n = 1'b0;
        full   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_winc",  64'(winc),      64'd0);
        chk("rst_grant", 64'(grant_id),  64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        wrst_n = 1'b1;
        tick();

        // ---------------- single requester, last on beat 3 ----------------
        for (int j = 0; j < 3; j++) begin
            push(2, 32'hA000_0000 + j, j == 2);
            expect_wr(2, 32'hA000_0000 + j);
        end
        tick();
        chk("t1_busy",  64'(busy),     64'd1);
        chk("t1_grant", 64'(grant_id), 64'd2);
        chk("t1_winc0", 64'(winc),     64'd1);
        tick();
        chk("t1_winc1", 64'(winc),     64'd1);
        tick();
        chk("t1_winc2", 64'(winc),     64'd1);
        tick();
        chk("t1_idle",  64'(busy),     64'd0);
        chk("t1_winc3", 64'(winc),     64'd0);

        // rr_ptr is now 3: requester 3 wins over requester 0
        push(0, 32'hB000_0000, 1'b1);
        push(3, 32'hC000_0000, 1'b1);
        expect_wr(3, 32'hC000_0000);
        expect_wr(0, 32'hB000_0000);
        tick();
        chk("rr_grant3", 64'(grant_id), 64'd3);
        drain("rr_drain");

        // ---------------- full stall mid-burst ----------------
        for (int j = 0; j < 5; j++) begin
            push(1, 32'hD100_0000 + j, j == 4);
            expect_wr(1, 32'hD100_0000 + j);
        end
        tick();
        chk("t3_grant", 64'(grant_id), 64'd1);
        chk("t3_winc0", 64'(winc),     64'd1);
        tick();
        chk("t3_winc1", 64'(winc),     64'd1);
        tick();
        full = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("t3_stall_winc",  64'(winc),      64'd0);
            chk("t3_stall_ready", 64'(req_ready), 64'd0);
            chk("t3_stall_busy",  64'(busy),      64'd1);
        end
        full = 1'b0;
        tick();
        chk("t3_resume",  64'(winc),      64'd1);
        chk("t3_stall_n", 64'(stall_cnt), STALL_EN ? 64'd5 : 64'd0);
        tick();
        chk("t3_rearb",   64'(busy),      64'd0);
        drain("t3_drain");

        // ---------------- owner drops valid after one beat ----------------
        push(3, 32'hE300_0000, 1'b0);
        push(3, 32'hE300_0001, 1'b1);
        push(1, 32'hE100_0000, 1'b1);
        expect_wr(3, 32'hE300_0000);
        expect_wr(1, 32'hE100_0000);
        expect_wr(3, 32'hE300_0001);
        tick();
        chk("t4_grant3", 64'(grant_id), 64'd3);
        chk("t4_winc",   64'(winc),     64'd1);
        tick();
        hold[3] = 1'b1;
        tick();
        chk("t4_release_busy", 64'(busy), 64'd0);
        chk("t4_release_winc", 64'(winc), 64'd0);
        tick();
        chk("t4_next_grant", 64'(grant_id), 64'd1);
        chk("t4_next_busy",  64'(busy),     64'd1);
        hold[3] = 1'b0;
        drain("t4_drain");

        // ---------------- reset in the middle of a burst ----------------
        push(1, 32'hF100_0000, 1'b1);
        for (int j = 0; j < 4; j++) push(2, 32'hF200_0000 + j, 1'b0);
        expect_wr(1, 32'hF100_0000);
        expect_wr(2, 32'hF200_0000);
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        chk("t5_pre_busy", 64'(busy), 64'd1);
        chk("t5_pre_winc", 64'(winc), 64'd1);
        wrst_n = 1'b0;
        #1;
        chk("t5_rst_winc",  64'(winc),      64'd0);
        chk("t5_rst_busy",  64'(busy),      64'd0);
        chk("t5_rst_ready", 64'(req_ready), 64'd0);
        chk("t5_rst_grant", 64'(grant_id),  64'd0);

        // All four requesters loaded while still in reset; requester 2 keeps
        // the three words that were not written before the reset.
        for (int j = 0; j < 8; j++) push(0, 32'h1000_0000 + j, 1'b0);
        for (int j = 0; j < 4; j++) push(1, 32'h1100_0000 + j, 1'b0);
        push(2, 32'h1200_0000, 1'b0);
        for (int j = 0; j < 4; j++) push(3, 32'h1300_0000 + j, 1'b0);
        for (int j = 0; j < 4; j++) expect_wr(0, 32'h1000_0000 + j);
        for (int j = 0; j < 4; j++) expect_wr(1, 32'h1100_0000 + j);
        for (int j = 1; j < 4; j++) expect_wr(2, 32'hF200_0000 + j);
        expect_wr(2, 32'h1200_0000);
        for (int j = 0; j < 4; j++) expect_wr(3, 32'h1300_0000 + j);
        for (int j = 4; j < 8; j++) expect_wr(0, 32'h1000_0000 + j);
        tick();
        tick();
        chk("t5_stall_clr", 64'(stall_cnt), 64'd0);
        wrst_n = 1'b1;

        // ---------------- all requesters valid, round robin ----------------
        k = 0;
        while (busy !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk("t2_first_grant", 64'(grant_id), 64'd0);
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            if (winc === 1'b1) cnt++;
            tick();
        end
        chk("t2_beats_in_20", 64'(cnt), 64'd16);
        drain("t2_drain");

        // ---------------- stall counter saturation ----------------
        full = 1'b1;
        push(0, 32'h2000_0000, 1'b1);
        expect_wr(0, 32'h2000_0000);
        for (int j = 0; j < 10; j++) tick();
        chk("t6_busy",        64'(busy),      64'd1);
        chk("t6_winc",        64'(winc),      64'd0);
        chk("t6_stall_early", 64'(stall_cnt), STALL_EN ? 64'd9 : 64'd0);
        for (int j = 0; j < 70000; j++) tick();
        chk("t6_stall_sat",   64'(stall_cnt), STALL_EN ? 64'hFFFF : 64'd0);
        full = 1'b0;
        drain("t6_drain");
        chk("t6_stall_hold",  64'(stall_cnt), STALL_EN ? 64'hFFFF : 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
